cellrv32_fetch_prefetch: RTL and testbench
==========================================

Name: cellrv32_fetch_prefetch

Overview:
Instruction prefetch unit directly upstream of the processor-internal instruction cache. It holds the fetch PC and issues word read requests on the i-cache host interface, one outstanding at a time. Responses, including error status, go into a first-word-fall-through FIFO that the decode stage drains. It handles branch/trap redirects and fence.i, and discards in-flight responses that belong to a stale PC.

Parameters:
PREFETCH_DEPTH, 4, FIFO entries (power of 2, >= 2)
RESET_PC, 32'h00000000, fetch PC after reset (word-aligned)

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, low-active, async
redirect_i  in  1  single-cycle: flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced 00)
fence_i_i  in  1  single-cycle: flush, clear i-cache, restart at redirect_pc_i
host_addr_o  out  32  i-cache access address
host_re_o  out  1  i-cache read enable, single-cycle pulse
host_rdata_i  in  32  i-cache read data
host_ack_i  in  1  i-cache transfer acknowledge
host_err_i  in  1  i-cache transfer error
cache_clear_o  out  1  i-cache clear request, single-cycle pulse
instr_o  out  32  FIFO head instruction word
instr_pc_o  out  32  address of FIFO head word
instr_err_o  out  1  FIFO head fetched with bus error
instr_valid_o  out  1  FIFO not empty
instr_ack_i  in  1  consumer pops head (ignored when instr_valid_o = 0)

Behaviour:
- Reset: fetch_pc = RESET_PC; FIFO empty; state S_REQ; host_re_o, cache_clear_o, instr_valid_o, instr_err_o = 0; instr_o and instr_pc_o = 0; pending = 0; discard = 0.
- host_addr_o = fetch_pc at all times, held stable while pending.
- The cache returns exactly one ack or err per request, arriving at least 2 cycles after host_re_o. Ack and err are never asserted together.
- FIFO entry = {err, pc, data}. instr_o, instr_pc_o and instr_err_o show the head combinationally. Pop when instr_valid_o & instr_ack_i.
- Free count = PREFETCH_DEPTH - fill. A request is issued only when free >= 1 after counting the outstanding one, so a response can never hit a full FIFO.
- FSM:
  - S_REQ: if space is available, pulse host_re_o, set pending, go to S_WAIT. Otherwise stay.
  - S_WAIT: on ack or err, clear pending.
    - discard = 1: drop the response, clear discard, go to S_REQ.
    - ack: push {0, fetch_pc, host_rdata_i}, fetch_pc += 4 (wraps modulo 2^32), go to S_REQ.
    - err: push {1, fetch_pc, host_rdata_i}, go to S_HALT.
  - S_HALT: no further requests. Leave only on redirect or fence.i.
- Redirect (redirect_i or fence_i_i), any state:
  - The FIFO is emptied in the same cycle. Redirect wins over a simultaneous pop and a simultaneous push.
  - fetch_pc = redirect_pc_i & ~3.
  - If pending, or a response arrives in the same cycle: the response is not pushed; set discard if the response is still outstanding. Next state S_WAIT while still outstanding, else S_REQ.
  - host_re_o is never pulsed in the redirect cycle.
- fence_i_i additionally pulses cache_clear_o for exactly 1 cycle, in the cycle after fence_i_i.
- If both redirect_i and fence_i_i are asserted, treat as fence_i_i.
- Simultaneous push and pop (no redirect): fill count unchanged, ordering preserved.
- Throughput: one word per cache round trip (no overlapping requests). After a response, the next host_re_o comes in the following cycle at the earliest.
- Reset mid-operation: async return to reset values. The cache resets concurrently, so no outstanding response survives.

Test Plan:
- Reset, cache acks each request after 2 cycles with data = addr, consumer always ready -> host_addr_o sequence 0x0, 0x4, 0x8; instr_o = instr_pc_o for each; host_re_o pulses exactly 1 cycle each.
- Consumer never acks, PREFETCH_DEPTH = 4 -> exactly 4 host_re_o pulses, then none. instr_valid_o = 1 with head pc 0x0. One pop -> exactly one new request at 0x10.
- Redirect to 0x80000102 while a request at 0x8 is pending, ack 3 cycles later -> that response is dropped. Next host_addr_o = 0x80000100. FIFO empty until the new ack.
- Cache returns err for 0xC -> entry {err = 1, pc = 0xC} delivered, no further host_re_o for 20 cycles. redirect_i to 0x40 -> fetch resumes at 0x40.
- fence_i_i with redirect_pc_i = 0x200 -> cache_clear_o high exactly 1 cycle, FIFO flushed, next request at 0x200.
- redirect_i with a simultaneous pop and a simultaneous ack -> FIFO empty next cycle, ack data not visible, fetch_pc = redirect target. PC wrap: redirect to 0xFFFFFFFC -> next request address is 0x00000000.

Source files
------------

// File: rtl/cellrv32_fetch_prefetch.sv
// Instruction prefetch: one outstanding i-cache word read at a time, responses queued
// in a first-word-fall-through FIFO for decode, with redirect/fence.i flush handling.
module cellrv32_fetch_prefetch #(
    parameter int unsigned PREFETCH_DEPTH = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        fence_i_i,
    output logic [31:0] host_addr_o,
    output logic        host_re_o,
    input  logic [31:0] host_rdata_i,
    input  logic        host_ack_i,
    input  logic        host_err_i,
    output logic        cache_clear_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    output logic        instr_valid_o,
    input  logic        instr_ack_i
);

    localparam int unsigned AW = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HALT
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_nxt;
    logic          discard;
    logic          discard_nxt;
    logic          run;
    logic          cache_clear;

    entry_t        fifo [PREFETCH_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] fill;
    entry_t        head;
    entry_t        push_entry;

    logic          flush;
    logic          resp;
    logic          push;
    logic          pop;
    logic          issue;
    logic          has_space;

    assign flush      = redirect_i | fence_i_i;
    assign resp       = host_ack_i | host_err_i;
    assign has_space  = (fill < CW'(PREFETCH_DEPTH));
    assign pop        = instr_valid_o & instr_ack_i & ~flush;
    assign push_entry = {host_err_i, fetch_pc, host_rdata_i};

    // Next-state / request / push decode; a flush overrides everything else.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = fetch_pc;
        discard_nxt = discard;
        issue       = 1'b0;
        push        = 1'b0;
        if (flush) begin
            pc_nxt = redirect_pc_i & ~32'h0000_0003;
            if ((state == S_WAIT) && !resp) begin
                state_nxt   = S_WAIT;
                discard_nxt = 1'b1;
            end else begin
                state_nxt   = S_REQ;
                discard_nxt = 1'b0;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (run && has_space) begin
                        issue     = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = S_REQ;
                        end else if (host_ack_i) begin
                            push      = 1'b1;
                            pc_nxt    = fetch_pc + 32'd4;
                            state_nxt = S_REQ;
                        end else begin
                            push      = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

    // run keeps the read strobe quiet while reset is asserted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            discard     <= 1'b0;
            run         <= 1'b0;
            cache_clear <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= pc_nxt;
            discard     <= discard_nxt;
            run         <= 1'b1;
            cache_clear <= fence_i_i;
        end
    end

    // Prefetch FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int unsigned i = 0; i < PREFETCH_DEPTH; i++) begin
                fifo[AW'(i)] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_entry;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill <= fill + CW'(1);
            end else if (pop && !push) begin
                fill <= fill - CW'(1);
            end
        end
    end

    assign head          = fifo[rd_ptr];
    assign instr_o       = head.data;
    assign instr_pc_o    = head.pc;
    assign instr_err_o   = head.err;
    assign instr_valid_o = (fill != '0);

    assign host_addr_o   = fetch_pc;
    assign host_re_o     = issue;
    assign cache_clear_o = cache_clear;

endmodule

// File: tb/tb_cellrv32_fetch_prefetch.sv
// Bench for the prefetch unit: i-cache responder with variable latency, and a consumer
// checking the delivered word stream against the expected sequential fetch stream.
module tb_cellrv32_fetch_prefetch;

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fence;
    logic [31:0] host_addr;
    logic        host_re;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        host_err;
    logic        cache_clear;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_err;
    logic        instr_valid;
    logic        instr_ack;

    int tests = 0;
    int fails = 0;

    // Cache environment
    int          lat_lo = 2;
    int          lat_hi = 2;
    int          lat_cnt;
    logic        busy;
    logic [31:0] req_addr;
    logic [31:0] last_req;
    int          re_count;
    int          overlap;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    // Reference stream model
    logic [31:0] exp_pc = 32'h0;
    logic        exp_halted = 1'b0;
    int          pops = 0;
    logic [31:0] last_pc = '0;
    logic        last_err = 1'b0;

    cellrv32_fetch_prefetch #(
        .PREFETCH_DEPTH(4),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .fence_i_i    (fence),
        .host_addr_o  (host_addr),
        .host_re_o    (host_re),
        .host_rdata_i (host_rdata),
        .host_ack_i   (host_ack),
        .host_err_i   (host_err),
        .cache_clear_o(cache_clear),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_err_o  (instr_err),
        .instr_valid_o(instr_valid),
        .instr_ack_i  (instr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic is_fence);
        step();
        redirect    = ~is_fence;
        fence       = is_fence;
        redirect_pc = tgt;
        exp_pc      = tgt & ~32'h3;
        exp_halted  = 1'b0;
        step();
        redirect = 1'b0;
        fence    = 1'b0;
    endtask

    task automatic wait_re(input string tag, input logic [31:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!host_re && n < 60);
        chk1({tag, "_seen"}, host_re, 1'b1);
        chk32(tag, host_addr, exp);
    endtask

    // Cache model: one response per sampled read strobe, 2+ cycles later.
    initial begin
        host_ack   = 1'b0;
        host_err   = 1'b0;
        host_rdata = '0;
        busy       = 1'b0;
        lat_cnt    = 0;
        re_count   = 0;
        overlap    = 0;
        req_addr   = '0;
        last_req   = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy = 1'b0;
            end else if (host_re) begin
                re_count++;
                if (busy) overlap++;
                busy     = 1'b1;
                req_addr = host_addr;
                last_req = host_addr;
                lat_cnt  = $urandom_range(lat_hi, lat_lo);
            end
            @(posedge clk);
            #1;
            host_ack = 1'b0;
            host_err = 1'b0;
            if (busy && rstn) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    host_rdata = mem_word(req_addr);
                    if (err_en && req_addr == err_addr) host_err = 1'b1;
                    else host_ack = 1'b1;
                    busy = 1'b0;
                end
            end
        end
    end

    // Consumer: every accepted pop must be the next word of the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && instr_valid && instr_ack && !redirect && !fence) begin
                if (exp_halted) begin
                    chk1("pop_after_err", instr_valid, 1'b0);
                end else begin
                    chk32("head_pc", instr_pc, exp_pc);
                    chk32("head_data", instr, mem_word(exp_pc));
                    chk1("head_err", instr_err, err_en && (exp_pc == err_addr));
                    last_pc  = instr_pc;
                    last_err = instr_err;
                    pops++;
                    if (err_en && exp_pc == err_addr) exp_halted = 1'b1;
                    else exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        int  r;
        int  n;
        logic found;
        logic [31:0] tgt;

        rstn        = 1'b0;
        redirect    = 1'b0;
        fence       = 1'b0;
        redirect_pc = '0;
        instr_ack   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk1("rst_re", host_re, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_err", instr_err, 1'b0);
        chk1("rst_clear", cache_clear, 1'b0);
        chk32("rst_instr", instr, 32'h0);
        chk32("rst_pc", instr_pc, 32'h0);
        chk32("rst_addr", host_addr, 32'h0);

        // Sequential fetch with an always-ready consumer
        step();
        rstn      = 1'b1;
        instr_ack = 1'b1;
        exp_pc    = 32'h0;
        pops      = 0;
        wait_re("s1_a0", 32'h0);
        wait_re("s1_a4", 32'h4);
        wait_re("s1_a8", 32'h8);
        steps(30);
        chk1("s1_rate", pops >= 8, 1'b1);

        // Backpressure: FIFO fills to depth, then one pop frees one slot
        instr_ack = 1'b0;
        do_redirect(32'h0, 1'b0);
        re_count = 0;
        steps(40);
        chk32("s2_reqs", re_count, 32'd4);
        chk1("s2_valid", instr_valid, 1'b1);
        chk32("s2_head_pc", instr_pc, 32'h0);
        chk32("s2_head_data", instr, mem_word(32'h0));
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        re_count  = 0;
        steps(20);
        chk32("s2_one_more", re_count, 32'd1);
        chk32("s2_addr", last_req, 32'h10);
        chk32("s2_new_head", instr_pc, 32'h4);

        // Redirect while a request is outstanding: its response is dropped
        lat_lo = 3;
        lat_hi = 3;
        instr_ack = 1'b1;
        do_redirect(32'h0, 1'b0);
        wait_re("s3_a0", 32'h0);
        wait_re("s3_a4", 32'h4);
        wait_re("s3_a8", 32'h8);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0102;
        exp_pc      = 32'h8000_0100;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk1("s3_flush", instr_valid, 1'b0);
        wait_re("s3_new", 32'h8000_0100);
        chk1("s3_empty", instr_valid, 1'b0);

        // Bus error halts fetch until a redirect
        lat_lo   = 2;
        lat_hi   = 2;
        err_en   = 1'b1;
        err_addr = 32'hC;
        do_redirect(32'h0, 1'b0);
        steps(30);
        chk32("s4_err_pc", last_pc, 32'hC);
        chk1("s4_err_flag", last_err, 1'b1);
        re_count = 0;
        steps(20);
        chk32("s4_no_req", re_count, 32'd0);
        err_en = 1'b0;
        do_redirect(32'h40, 1'b0);
        @(negedge clk);
        chk1("s4_resume_re", host_re, 1'b1);
        chk32("s4_resume", host_addr, 32'h40);

        // fence.i: flush, one-cycle cache clear, restart at target
        instr_ack = 1'b0;
        steps(25);
        @(negedge clk);
        chk1("s5_full", instr_valid, 1'b1);
        step();
        fence       = 1'b1;
        redirect_pc = 32'h200;
        exp_pc      = 32'h200;
        exp_halted  = 1'b0;
        @(negedge clk);
        chk1("s5_clr_early", cache_clear, 1'b0);
        step();
        fence     = 1'b0;
        instr_ack = 1'b1;
        @(negedge clk);
        chk1("s5_clr", cache_clear, 1'b1);
        chk1("s5_flushed", instr_valid, 1'b0);
        chk1("s5_re", host_re, 1'b1);
        chk32("s5_addr", host_addr, 32'h200);
        step();
        @(negedge clk);
        chk1("s5_clr_late", cache_clear, 1'b0);

        // Redirect colliding with a pop and an ack in the same cycle
        lat_lo    = 3;
        lat_hi    = 3;
        instr_ack = 1'b0;
        do_redirect(32'h100, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            n++;
            if (instr_valid && busy && lat_cnt == 1) found = 1'b1;
        end
        chk1("s6_setup", found, 1'b1);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        exp_pc      = 32'h300;
        instr_ack   = 1'b1;
        @(negedge clk);
        chk1("s6_ack_same", host_ack, 1'b1);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk1("s6_empty", instr_valid, 1'b0);
        chk1("s6_re", host_re, 1'b1);
        chk32("s6_addr", host_addr, 32'h300);

        // PC wrap-around
        lat_lo = 2;
        lat_hi = 2;
        do_redirect(32'hFFFF_FFFC, 1'b0);
        wait_re("s7_top", 32'hFFFF_FFFC);
        wait_re("s7_wrap", 32'h0);
        steps(10);

        // Randomized traffic: latency, backpressure, redirects, fences, errors
        lat_lo = 2;
        lat_hi = 5;
        repeat (600) begin
            step();
            redirect  = 1'b0;
            fence     = 1'b0;
            instr_ack = ($urandom_range(3, 0) != 0);
            r = $urandom_range(99, 0);
            if (r < 3) begin
                tgt         = $urandom;
                redirect_pc = tgt;
                redirect    = (r != 0);
                fence       = (r != 1);
                exp_pc      = tgt & ~32'h3;
                exp_halted  = 1'b0;
                err_en      = ($urandom_range(1, 0) == 1);
                err_addr    = (tgt & ~32'h3) + 32'($urandom_range(20, 2) * 4);
            end
        end
        step();
        redirect = 1'b0;
        fence    = 1'b0;
        err_en   = 1'b0;
        lat_lo   = 2;
        lat_hi   = 2;

        // Asynchronous reset in the middle of traffic
        instr_ack = 1'b1;
        do_redirect(32'h1000, 1'b0);
        steps(7);
        rstn       = 1'b0;
        exp_pc     = 32'h0;
        exp_halted = 1'b0;
        #1;
        chk1("s9_valid", instr_valid, 1'b0);
        chk1("s9_re", host_re, 1'b0);
        chk32("s9_addr", host_addr, 32'h0);
        steps(3);
        rstn = 1'b1;
        pops = 0;
        wait_re("s9_restart", 32'h0);
        steps(30);
        chk1("s9_stream", pops >= 8, 1'b1);

        chk32("overlap", overlap, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
